fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instr_hold_reg.sv | 21 ++
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states and
// PC-mux select encodings.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam logic [1:0] PC4  = 2'b00;
    localparam logic [1:0] PCB  = 2'b01;
    localparam logic [1:0] PCJR = 2'b10;

endpackage

// File: rtl/instr_hold_reg.sv
// Load-enabled, clearable register that parks a fetched instruction while
// the decode stage is stalled.
module instr_hold_reg #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues one memory request at a time, delivers
// or parks the response, and applies branch/jalr redirects in the same cycle.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ready,
    input  logic              im_rvalid,
    input  logic [ADDR_W-1:0] im_rdata,
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic              redirect,
    input  logic [1:0]        redirect_sel,
    input  logic              hazard_stall,
    output logic              pc_write,
    output logic [1:0]        branch_ctrl,
    output logic              ifid_write,
    output logic              instr_flush,
    output logic [ADDR_W-1:0] instr_out
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              stale;
    logic              stale_nxt;
    logic              deliver_wait;
    logic              deliver_hold;
    logic              hold_ld;
    logic              hold_clr;
    logic [ADDR_W-1:0] hold_q;

    assign deliver_wait = (state == WAIT) && im_rvalid && !redirect && !hazard_stall;
    assign deliver_hold = (state == HOLD) && !redirect && !hazard_stall;
    assign hold_ld      = (state == WAIT) && im_rvalid && !redirect && hazard_stall;
    assign hold_clr     = !rst || ((state == HOLD) && (redirect || !hazard_stall));

    instr_hold_reg #(
        .ADDR_W(ADDR_W)
    ) u_hold (
        .clk(clk),
        .clr(hold_clr),
        .ld (hold_ld),
        .d  (im_rdata),
        .q  (hold_q)
    );

    // A redirect while a request is still unaccepted cannot retract it (address
    // must stay stable), so its eventual response is marked stale and dropped.
    always_comb begin
        state_nxt = state;
        stale_nxt = stale;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (im_ready) begin
                    state_nxt = (stale || redirect) ? DROP : WAIT;
                    stale_nxt = 1'b0;
                end else if (redirect) begin
                    stale_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (im_rvalid) begin
                    state_nxt = (!redirect && hazard_stall) ? HOLD : REQ;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            HOLD: begin
                if (redirect || !hazard_stall) begin
                    state_nxt = REQ;
                end
            end
            DROP: begin
                if (im_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            stale   <= 1'b0;
            im_req  <= 1'b0;
            im_addr <= '0;
        end else begin
            state  <= state_nxt;
            stale  <= stale_nxt;
            im_req <= (state_nxt == REQ);
            if ((state_nxt == REQ) && (state != REQ)) begin
                im_addr <= pc_cur;
            end
        end
    end

    // Pipeline controls are combinational so redirects and deliveries act in
    // the cycle they occur; everything is forced low while reset is held.
    always_comb begin
        pc_write    = 1'b0;
        branch_ctrl = PC4;
        ifid_write  = 1'b0;
        instr_flush = 1'b0;
        instr_out   = '0;
        if (rst) begin
            if (redirect) begin
                pc_write    = 1'b1;
                branch_ctrl = redirect_sel;
                ifid_write  = 1'b1;
                instr_flush = 1'b1;
            end else if (deliver_wait || deliver_hold) begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                instr_out  = deliver_wait ? im_rdata : hold_q;
            end else if ((state != IDLE) && !hazard_stall) begin
                ifid_write  = 1'b1;
                instr_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; PC-changing events are predicted into a queue
// and checked by an independent monitor, other outputs are checked inline.
module tb_fetch_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_ready = 1'b0;
    logic              im_rvalid = 1'b0;
    logic [ADDR_W-1:0] im_rdata = '0;
    logic [ADDR_W-1:0] pc_cur = '0;
    logic              redirect = 1'b0;
    logic [1:0]        redirect_sel = 2'b00;
    logic              hazard_stall = 1'b0;
    logic              pc_write;
    logic [1:0]        branch_ctrl;
    logic              ifid_write;
    logic              instr_flush;
    logic [ADDR_W-1:0] instr_out;

    fetch_ctrl #(
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ready    (im_ready),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .pc_cur      (pc_cur),
        .redirect    (redirect),
        .redirect_sel(redirect_sel),
        .hazard_stall(hazard_stall),
        .pc_write    (pc_write),
        .branch_ctrl (branch_ctrl),
        .ifid_write  (ifid_write),
        .instr_flush (instr_flush),
        .instr_out   (instr_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        bc;
        logic              flush;
        logic [ADDR_W-1:0] out;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, req);
    endtask

    task automatic chk_ctrl(input string nm, input logic pw, input logic iw, input logic fl);
        chk(nm, {29'd0, pc_write, ifid_write, instr_flush}, {29'd0, pw, iw, fl});
    endtask

    task automatic expect_ev(input logic [1:0] bc, input logic fl, input logic [ADDR_W-1:0] out);
        ev_t e;
        e.bc    = bc;
        e.flush = fl;
        e.out   = out;
        exp_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && pc_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pc_write_unexpected", {31'd0, pc_write}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_branch_ctrl", {30'd0, branch_ctrl}, {30'd0, mon_e.bc});
                chk("ev_ifid_write", {31'd0, ifid_write}, 32'd1);
                chk("ev_instr_flush", {31'd0, instr_flush}, {31'd0, mon_e.flush});
                chk("ev_instr_out", instr_out, mon_e.out);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // reset held
        @(negedge clk);
        chk("rst_ctrl", {27'd0, im_req, pc_write, ifid_write, instr_flush, branch_ctrl}, 32'd0);
        chk("rst_addr", im_addr, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        next_cyc();
        // first cycle after release: IDLE
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ctrl", {27'd0, im_req, pc_write, ifid_write, instr_flush, branch_ctrl}, 32'd0);
        next_cyc();
        // REQ accepted immediately
        im_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", {31'd0, im_req}, 32'd1);
        chk("req_addr", im_addr, 32'h0);
        chk_ctrl("req_bubble", 1'b0, 1'b1, 1'b1);
        next_cyc();
        im_ready = 1'b0;
        @(negedge clk);
        chk("wait_noreq", {31'd0, im_req}, 32'd0);
        chk_ctrl("wait_bubble", 1'b0, 1'b1, 1'b1);
        next_cyc();
        // response two cycles after acceptance, delivered same cycle
        im_rvalid = 1'b1;
        im_rdata  = 32'h0000_0013;
        expect_ev(2'b00, 1'b0, 32'h0000_0013);
        @(negedge clk);
        next_cyc();
        im_rvalid = 1'b0;
        im_rdata  = '0;
        // memory not ready for 3 cycles: address must not move
        for (int i = 0; i < 3; i++) begin
            if (i == 1) pc_cur = 32'h100;
            @(negedge clk);
            chk("stall_req", {31'd0, im_req}, 32'd1);
            chk("stall_addr", im_addr, 32'h0);
            chk_ctrl("stall_bubble", 1'b0, 1'b1, 1'b1);
            next_cyc();
        end
        im_ready = 1'b1;
        @(negedge clk);
        chk("accept_addr", im_addr, 32'h0);
        next_cyc();
        // response under hazard stall -> HOLD
        im_ready     = 1'b0;
        im_rvalid    = 1'b1;
        im_rdata     = 32'h0010_0093;
        hazard_stall = 1'b1;
        @(negedge clk);
        chk_ctrl("wait_stall", 1'b0, 1'b0, 1'b0);
        chk("wait_stall_out", instr_out, 32'h0);
        next_cyc();
        im_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk_ctrl("hold_stall", 1'b0, 1'b0, 1'b0);
        chk("hold_noreq", {31'd0, im_req}, 32'd0);
        next_cyc();
        im_rvalid    = 1'b0;
        im_rdata     = '0;
        hazard_stall = 1'b0;
        expect_ev(2'b00, 1'b0, 32'h0010_0093);
        @(negedge clk);
        next_cyc();
        im_ready = 1'b1;
        @(negedge clk);
        chk("req2_addr", im_addr, 32'h100);
        chk("req2_valid", {31'd0, im_req}, 32'd1);
        next_cyc();
        // branch redirect in WAIT with no response yet
        im_ready     = 1'b0;
        redirect     = 1'b1;
        redirect_sel = 2'b01;
        expect_ev(2'b01, 1'b1, 32'h0);
        @(negedge clk);
        next_cyc();
        redirect     = 1'b0;
        redirect_sel = 2'b00;
        pc_cur       = 32'h200;
        @(negedge clk);
        chk("drop_noreq", {31'd0, im_req}, 32'd0);
        chk_ctrl("drop_bubble", 1'b0, 1'b1, 1'b1);
        next_cyc();
        im_rvalid = 1'b1;
        im_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("drop_out", instr_out, 32'h0);
        chk_ctrl("drop_discard", 1'b0, 1'b1, 1'b1);
        next_cyc();
        im_rvalid = 1'b0;
        im_rdata  = '0;
        im_ready  = 1'b1;
        @(negedge clk);
        chk("redir_addr", im_addr, 32'h200);
        chk("redir_req", {31'd0, im_req}, 32'd1);
        next_cyc();
        // jalr redirect while held and still stalled
        im_ready     = 1'b0;
        im_rvalid    = 1'b1;
        im_rdata     = 32'h0020_0113;
        hazard_stall = 1'b1;
        @(negedge clk);
        chk_ctrl("wait_stall2", 1'b0, 1'b0, 1'b0);
        next_cyc();
        im_rvalid    = 1'b0;
        im_rdata     = '0;
        redirect     = 1'b1;
        redirect_sel = 2'b10;
        pc_cur       = 32'h300;
        expect_ev(2'b10, 1'b1, 32'h0);
        @(negedge clk);
        next_cyc();
        redirect     = 1'b0;
        redirect_sel = 2'b00;
        hazard_stall = 1'b0;
        @(negedge clk);
        chk("jalr_addr", im_addr, 32'h300);
        chk("held_dropped_out", instr_out, 32'h0);
        chk_ctrl("held_dropped_ctrl", 1'b0, 1'b1, 1'b1);
        next_cyc();
        // redirect before acceptance: old request still issued, response dropped
        redirect     = 1'b1;
        redirect_sel = 2'b01;
        pc_cur       = 32'h400;
        expect_ev(2'b01, 1'b1, 32'h0);
        @(negedge clk);
        next_cyc();
        redirect     = 1'b0;
        redirect_sel = 2'b00;
        im_ready     = 1'b1;
        @(negedge clk);
        chk("stale_addr", im_addr, 32'h300);
        chk("stale_req", {31'd0, im_req}, 32'd1);
        next_cyc();
        im_ready  = 1'b0;
        im_rvalid = 1'b1;
        im_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("stale_out", instr_out, 32'h0);
        chk("stale_noreq", {31'd0, im_req}, 32'd0);
        next_cyc();
        im_rvalid = 1'b0;
        im_rdata  = '0;
        im_ready  = 1'b1;
        @(negedge clk);
        chk("post_stale_addr", im_addr, 32'h400);
        next_cyc();
        // reset asserted while in WAIT
        im_ready = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk_ctrl("rst_wait_ctrl", 1'b0, 1'b0, 1'b0);
        next_cyc();
        rst       = 1'b1;
        im_rvalid = 1'b1;
        im_rdata  = 32'h1234_5678;
        @(negedge clk);
        chk("rst2_ctrl", {27'd0, im_req, pc_write, ifid_write, instr_flush, branch_ctrl}, 32'd0);
        chk("rst2_addr", im_addr, 32'h0);
        chk("rst2_out", instr_out, 32'h0);
        next_cyc();
        im_rvalid = 1'b0;
        im_rdata  = '0;
        @(negedge clk);
        chk("rst2_req", {31'd0, im_req}, 32'd1);
        chk("rst2_req_addr", im_addr, 32'h400);
        chk_ctrl("rst2_bubble", 1'b0, 1'b1, 1'b1);
        next_cyc();
        repeat (2) next_cyc();
        chk("events_pending", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
